// File: rtl/phy_rx_serial_align_if.sv
// phy_rx_serial_align_if: serial lane input and received byte outputs of the receive aligner
interface phy_rx_serial_align_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  modport master (output serial_in, input data_out, valid_out, byte_strobe, active);
  modport slave (input serial_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/phy_rx_serial_align.sv
// phy_rx_serial_align: comma-hunting byte aligner that delivers one byte per 8 bit-times once locked
module phy_rx_serial_align #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input logic                   clk_8f,
  input logic                   reset,
  phy_rx_serial_align_if.slave  lane
);
  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;
  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic       valid_q, valid_d, strobe_q, strobe_d;
  logic       comma, byte_done;
  assign sh_d      = {sh_q[6:0], lane.serial_in};
  assign comma     = sh_d == COMMA;
  assign byte_done = (state_q != SEARCH) && (bit_cnt_q == 3'd7);
  // All state and output registers; reset discards any partial byte and alignment
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sh_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end
  // Next state: hunt the comma bit by bit, then require aligned commas until lock
  always_comb begin
    state_d   = state_q;
    bc_cnt_d  = bc_cnt_q;
    bit_cnt_d = (state_q == SEARCH) ? 3'd0 : bit_cnt_q + 3'd1;
    if (state_q == SEARCH && comma) begin
      state_d  = SYNC;
      bc_cnt_d = 4'd1;
    end else if (state_q == SYNC && byte_done) begin
      bc_cnt_d = comma ? bc_cnt_q + 4'd1 : 4'd0;
      state_d  = !comma ? SEARCH : (bc_cnt_q + 4'd1 == 4'(LOCK_COUNT)) ? ACTIVE : SYNC;
    end
  end
  // Byte outputs: load and strobe at each aligned byte boundary while active, else hold
  always_comb begin
    strobe_d = (state_q == ACTIVE) && byte_done;
    data_d   = strobe_d ? sh_d : data_q;
    valid_d  = strobe_d ? !comma : valid_q;
  end
  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = state_q == ACTIVE;
endmodule

// File: tb/tb_phy_rx_serial_align.sv
// tb_phy_rx_serial_align: directed checks of reset, lock, data delivery, bit offset, false lock and relock
module tb_phy_rx_serial_align;
  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ns;
  phy_rx_serial_align_if bus ();
  phy_rx_serial_align dut (.clk_8f(clk_8f), .reset(reset), .lane(bus));
  always #5 clk_8f = ~clk_8f;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b, inout int n);
    bus.serial_in = b;
    @(posedge clk_8f);
    #1;
    if (bus.byte_strobe === 1'b1) n++;
  endtask
  task automatic send_byte(input logic [7:0] b, inout int n);
    for (int i = 7; i >= 0; i--) send_bit(b[i], n);
  endtask
  task automatic pulse_reset(input string tag);
    @(negedge clk_8f);
    reset = 1'b1;
    #1;
    chk({tag, "_data"}, bus.data_out, 8'h00);
    chk({tag, "_valid"}, bus.valid_out, 1'b0);
    chk({tag, "_strobe"}, bus.byte_strobe, 1'b0);
    chk({tag, "_active"}, bus.active, 1'b0);
    @(negedge clk_8f);
    reset = 1'b0;
  endtask
  initial begin
    bus.serial_in = 1'b0;
    #2;
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_strobe", bus.byte_strobe, 1'b0);
    chk("rst_active", bus.active, 1'b0);
    @(negedge clk_8f);
    reset = 1'b0;
    ns = 0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC, ns);
      chk("lock_pre_active", bus.active, 1'b0);
    end
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hBC >> i), ns);
    chk("lock_bit1_active", bus.active, 1'b0);
    send_bit(1'b0, ns);
    chk("lock_active", bus.active, 1'b1);
    chk("lock_no_strobe", ns, 0);
    ns = 0;
    send_byte(8'h5A, ns);
    chk("d0_strobe", bus.byte_strobe, 1'b1);
    chk("d0_count", ns, 1);
    chk("d0_data", bus.data_out, 8'h5A);
    chk("d0_valid", bus.valid_out, 1'b1);
    ns = 0;
    send_byte(8'hBC, ns);
    chk("d1_strobe", bus.byte_strobe, 1'b1);
    chk("d1_count", ns, 1);
    chk("d1_data", bus.data_out, 8'hBC);
    chk("d1_valid", bus.valid_out, 1'b0);
    ns = 0;
    send_byte(8'hFF, ns);
    chk("d2_strobe", bus.byte_strobe, 1'b1);
    chk("d2_count", ns, 1);
    chk("d2_data", bus.data_out, 8'hFF);
    chk("d2_valid", bus.valid_out, 1'b1);
    ns = 0;
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h34 >> i), ns);
    chk("hold_strobe", bus.byte_strobe, 1'b0);
    chk("hold_data", bus.data_out, 8'hFF);
    chk("hold_count", ns, 0);
    pulse_reset("midrst");
    ns = 0;
    for (int k = 0; k < 3; k++) send_byte(8'hBC, ns);
    chk("relock_pre_active", bus.active, 1'b0);
    send_byte(8'hBC, ns);
    chk("relock_active", bus.active, 1'b1);
    chk("relock_no_strobe", ns, 0);
    pulse_reset("rst_off");
    ns = 0;
    send_bit(1'b1, ns);
    send_bit(1'b0, ns);
    send_bit(1'b1, ns);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, ns);
    chk("off_pre_active", bus.active, 1'b0);
    send_byte(8'hBC, ns);
    chk("off_active", bus.active, 1'b1);
    send_byte(8'h12, ns);
    chk("off_count", ns, 1);
    chk("off_data", bus.data_out, 8'h12);
    chk("off_valid", bus.valid_out, 1'b1);
    pulse_reset("rst_false");
    ns = 0;
    send_byte(8'hBC, ns);
    send_byte(8'hBC, ns);
    send_byte(8'h00, ns);
    chk("false_after_zero", bus.active, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, ns);
    chk("false_third_comma", bus.active, 1'b0);
    send_byte(8'hBC, ns);
    chk("false_lock", bus.active, 1'b1);
    chk("false_no_strobe", ns, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
